// File: rtl/sbox_share_compress.sv
// Share refresh and compression after the masked AES inversion.
// Four inversion shares in, two affine-mapped S-box shares out.
//
// Ports:
//   CLK, RST_N           rising-edge clock, synchronous active-low reset
//   seed_load, seed      load a 32-bit LFSR seed (0 maps to 1)
//   in_valid, in_ready   input handshake
//   in0..in3             inversion output shares, XOR = X^-1
//   out_valid, out_ready output handshake
//   out0, out1           S-box output shares, XOR = S(X)

module sbox_share_compress (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        seed_load,
  input  logic [31:0] seed,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in0,
  input  logic [7:0]  in1,
  input  logic [7:0]  in2,
  input  logic [7:0]  in3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out0,
  output logic [7:0]  out1
);

  typedef enum logic {
    UNSEEDED = 1'b0,
    RUN      = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] lfsr;
  logic [31:0] lfsr_step;
  logic [31:0] seed_fix;
  logic [7:0]  ra;
  logic [7:0]  rb;
  logic        advance;
  logic        accept;

  logic        v1;
  logic [7:0]  s0;
  logic [7:0]  s1;
  logic [7:0]  s2;
  logic [7:0]  s3;

  logic [7:0]  c0;
  logic [7:0]  c1;

  // Linear part of the AES affine map, no constant.
  function automatic logic [7:0] aff_lin(
    input logic [7:0] x
  );
    logic [7:0] b;
    b[0] = x[0] ^ x[4] ^ x[5] ^ x[6] ^ x[7];
    b[1] = x[1] ^ x[5] ^ x[6] ^ x[7] ^ x[0];
    b[2] = x[2] ^ x[6] ^ x[7] ^ x[0] ^ x[1];
    b[3] = x[3] ^ x[7] ^ x[0] ^ x[1] ^ x[2];
    b[4] = x[4] ^ x[0] ^ x[1] ^ x[2] ^ x[3];
    b[5] = x[5] ^ x[1] ^ x[2] ^ x[3] ^ x[4];
    b[6] = x[6] ^ x[2] ^ x[3] ^ x[4] ^ x[5];
    b[7] = x[7] ^ x[3] ^ x[4] ^ x[5] ^ x[6];
    return b;
  endfunction

  // Global stall: everything moves only when the output
  // register is empty or being drained.
  assign advance  = !out_valid | out_ready;
  assign in_ready = (state == RUN) & advance;
  assign accept   = in_valid & in_ready;

  // Masks come from the pre-step LFSR value.
  assign ra = lfsr[7:0];
  assign rb = lfsr[15:8];

  assign lfsr_step = lfsr[0]
    ? ({1'b0, lfsr[31:1]} ^ 32'h8020_0003)
    : {1'b0, lfsr[31:1]};

  // An all-zero state would lock the LFSR.
  assign seed_fix = (seed == 32'h0)
    ? 32'h0000_0001
    : seed;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= UNSEEDED;
    end else begin
      unique case (state)
        UNSEEDED: begin
          if (seed_load) begin
            state <= RUN;
          end
        end
        RUN: begin
          state <= RUN;
        end
      endcase
    end
  end

  // A seed in the same cycle as a beat wins; the beat
  // has already consumed the old value.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      lfsr <= 32'h0000_0001;
    end else if (seed_load) begin
      lfsr <= seed_fix;
    end else if (accept) begin
      lfsr <= lfsr_step;
    end
  end

  // Stage 1: each share is refreshed on its own; the
  // masks ra, rb, ra^rb cancel in the total XOR.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      v1 <= 1'b0;
      s0 <= 8'h00;
      s1 <= 8'h00;
      s2 <= 8'h00;
      s3 <= 8'h00;
    end else if (advance) begin
      v1 <= accept;
      if (accept) begin
        s0 <= in0 ^ ra;
        s1 <= in1 ^ rb;
        s2 <= in2 ^ ra ^ rb;
        s3 <= in3;
      end
    end
  end

  // Compression happens only after the refresh register.
  assign c0 = aff_lin(s0 ^ s1) ^ 8'h63;
  assign c1 = aff_lin(s2 ^ s3);

  // Stage 2: output register, frozen while stalled.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_valid <= 1'b0;
      out0      <= 8'h00;
      out1      <= 8'h00;
    end else if (advance) begin
      out_valid <= v1;
      if (v1) begin
        out0 <= c0;
        out1 <= c1;
      end
    end
  end

endmodule

// File: tb/tb_sbox_share_compress.sv
// Directed bench for sbox_share_compress.
// Expected shares come from a bench-side LFSR and GF(2^8) model.

module tb_sbox_share_compress;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        seed_load = 1'b0;
  logic [31:0] seed = 32'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in0 = 8'h00;
  logic [7:0]  in1 = 8'h00;
  logic [7:0]  in2 = 8'h00;
  logic [7:0]  in3 = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out0;
  logic [7:0]  out1;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] sx;
  } exp_t;

  exp_t        q[$];
  exp_t        last;
  logic [31:0] mlfsr;
  logic [7:0]  inv [256];

  sbox_share_compress dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .seed_load (seed_load),
    .seed      (seed),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out0      (out0),
    .out1      (out1)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] nxt(input logic [31:0] l);
    logic [31:0] r;
    r = l >> 1;
    if (l[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  // Textbook rotate form of the affine linear part.
  function automatic logic [7:0] lin(input logic [7:0] x);
    return x
      ^ {x[6:0], x[7]}
      ^ {x[5:0], x[7:6]}
      ^ {x[4:0], x[7:5]}
      ^ {x[3:0], x[7:4]};
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return lin(inv[x]) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sx_of(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] c,
    input logic [7:0] d
  );
    return sbox(inv[a ^ b ^ c ^ d]);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Present one beat that must be accepted at the next edge.
  task automatic beat(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] c,
    input logic [7:0] d,
    input logic [7:0] sx,
    input string      tag
  );
    exp_t e;
    in0 = a;
    in1 = b;
    in2 = c;
    in3 = d;
    in_valid = 1'b1;
    #1;
    chk({tag, "_rdy"}, {31'b0, in_ready}, 1);
    e.e0 = lin(a ^ b ^ mlfsr[7:0] ^ mlfsr[15:8]) ^ 8'h63;
    e.e1 = lin(c ^ d ^ mlfsr[7:0] ^ mlfsr[15:8]);
    e.sx = sx;
    q.push_back(e);
    mlfsr = nxt(mlfsr);
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic pop_chk(input string tag);
    total++;
    assert (q.size() != 0) else begin
      bad++;
      $error("FAIL %s_q obs=empty exp=entry", tag);
    end
    if (q.size() != 0) begin
      last = q.pop_front();
      chk({tag, "_v"}, {31'b0, out_valid}, 1);
      chk({tag, "_o0"}, {24'b0, out0}, {24'b0, last.e0});
      chk({tag, "_o1"}, {24'b0, out1}, {24'b0, last.e1});
      chk({tag, "_sx"}, {24'b0, out0 ^ out1}, {24'b0, last.sx});
    end
  endtask

  initial begin
    logic [7:0]  r1;
    logic [7:0]  r2;
    logic [7:0]  r3;
    logic [7:0]  dd;
    logic [7:0]  oa;
    logic [7:0]  ob;
    logic [31:0] l4;

    inv[0] = 8'h00;
    for (int a = 1; a < 256; a++) begin
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv[a] = 8'(b);
      end
    end
    mlfsr = 32'h1;

    // Reset and seeding
    RST_N = 1'b0;
    tick();
    tick();
    chk("rst_v", {31'b0, out_valid}, 0);
    chk("rst_rdy", {31'b0, in_ready}, 0);
    chk("rst_o0", {24'b0, out0}, 0);
    chk("rst_o1", {24'b0, out1}, 0);
    chk("rst_lfsr", dut.lfsr, 32'h1);
    RST_N = 1'b1;
    tick();
    chk("unseed_rdy", {31'b0, in_ready}, 0);

    seed_load = 1'b1;
    seed = 32'h0;
    #1;
    chk("seed_cyc_rdy", {31'b0, in_ready}, 0);
    tick();
    seed_load = 1'b0;
    chk("seed0_rdy", {31'b0, in_ready}, 1);
    chk("seed0_lfsr", dut.lfsr, 32'h1);

    seed_load = 1'b1;
    seed = 32'hDEAD_BEEF;
    tick();
    seed_load = 1'b0;
    mlfsr = 32'hDEAD_BEEF;
    chk("seed_db", dut.lfsr, 32'hDEAD_BEEF);

    // Directed values
    beat(8'h12, 8'h34, 8'h56, 8'hBA, 8'hED, "d53");
    chk("d_fill", {31'b0, out_valid}, 0);
    beat(8'h11, 8'h22, 8'h44, 8'h77, 8'h63, "d00");
    pop_chk("d53");
    beat(8'hA5, 8'h5A, 8'h0F, 8'hF1, 8'h7C, "d01");
    pop_chk("d00");
    idle();
    pop_chk("d01");
    idle();
    chk("d_drain", {31'b0, out_valid}, 0);

    // All 256 inputs with random splits
    for (int i = 0; i <= 256; i++) begin
      if (i < 256) begin
        r1 = 8'($urandom);
        r2 = 8'($urandom);
        r3 = 8'($urandom);
        dd = inv[i] ^ r1 ^ r2 ^ r3;
        beat(r1, r2, r3, dd, sbox(8'(i)), "ex");
      end else begin
        idle();
      end
      if (i > 0) pop_chk($sformatf("ex%0d", i - 1));
      else chk("ex_fill", {31'b0, out_valid}, 0);
    end
    idle();
    chk("ex_drain", {31'b0, out_valid}, 0);

    // Backpressure
    l4 = mlfsr;
    beat(8'h01, 8'h02, 8'h03, 8'h04,
         sx_of(8'h01, 8'h02, 8'h03, 8'h04), "bp0");
    beat(8'h10, 8'h20, 8'h30, 8'h47,
         sx_of(8'h10, 8'h20, 8'h30, 8'h47), "bp1");
    pop_chk("bp0");
    out_ready = 1'b0;
    in0 = 8'h9A;
    in1 = 8'hBC;
    in2 = 8'hDE;
    in3 = 8'hF0;
    in_valid = 1'b1;
    #1;
    chk("bp_rdy_comb", {31'b0, in_ready}, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp_v%0d", k), {31'b0, out_valid}, 1);
      chk($sformatf("bp_o0_%0d", k), {24'b0, out0},
          {24'b0, last.e0});
      chk($sformatf("bp_o1_%0d", k), {24'b0, out1},
          {24'b0, last.e1});
      chk($sformatf("bp_rdy%0d", k), {31'b0, in_ready}, 0);
    end
    out_ready = 1'b1;
    beat(8'h9A, 8'hBC, 8'hDE, 8'hF0,
         sx_of(8'h9A, 8'hBC, 8'hDE, 8'hF0), "bp2");
    pop_chk("bp1");
    beat(8'hFF, 8'h00, 8'h0F, 8'hA0,
         sx_of(8'hFF, 8'h00, 8'h0F, 8'hA0), "bp3");
    pop_chk("bp2");
    idle();
    pop_chk("bp3");
    idle();
    chk("bp_drain", {31'b0, out_valid}, 0);
    repeat (4) l4 = nxt(l4);
    chk("bp_lfsr4", dut.lfsr, l4);

    // Randomness and replay
    seed_load = 1'b1;
    seed = 32'hDEAD_BEEF;
    tick();
    seed_load = 1'b0;
    mlfsr = 32'hDEAD_BEEF;
    beat(8'h3C, 8'hC3, 8'h5A, 8'h96,
         sx_of(8'h3C, 8'hC3, 8'h5A, 8'h96), "rn0");
    beat(8'h3C, 8'hC3, 8'h5A, 8'h96,
         sx_of(8'h3C, 8'hC3, 8'h5A, 8'h96), "rn1");
    pop_chk("rn0");
    oa = out0;
    seed_load = 1'b1;
    seed = 32'hDEAD_BEEF;
    beat(8'h3C, 8'hC3, 8'h5A, 8'h96,
         sx_of(8'h3C, 8'hC3, 8'h5A, 8'h96), "rn2");
    seed_load = 1'b0;
    mlfsr = 32'hDEAD_BEEF;
    pop_chk("rn1");
    ob = out0;
    total++;
    assert (oa !== ob) else begin
      bad++;
      $error("FAIL rn_differ obs=%h exp=not_%h", ob, oa);
    end
    chk("rn_seed_same_cyc", dut.lfsr, 32'hDEAD_BEEF);
    beat(8'h3C, 8'hC3, 8'h5A, 8'h96,
         sx_of(8'h3C, 8'hC3, 8'h5A, 8'h96), "rp0");
    pop_chk("rn2");
    beat(8'h3C, 8'hC3, 8'h5A, 8'h96,
         sx_of(8'h3C, 8'hC3, 8'h5A, 8'h96), "rp1");
    pop_chk("rp0");
    chk("rp0_same", {24'b0, last.e0}, {24'b0, oa});
    idle();
    pop_chk("rp1");
    idle();

    // Reset with two beats in flight
    beat(8'h21, 8'h43, 8'h65, 8'h87,
         sx_of(8'h21, 8'h43, 8'h65, 8'h87), "mr0");
    beat(8'h12, 8'h34, 8'h56, 8'h78,
         sx_of(8'h12, 8'h34, 8'h56, 8'h78), "mr1");
    RST_N = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("mr_v", {31'b0, out_valid}, 0);
    chk("mr_rdy", {31'b0, in_ready}, 0);
    chk("mr_o0", {24'b0, out0}, 0);
    chk("mr_lfsr", dut.lfsr, 32'h1);
    q.delete();
    RST_N = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("mr_hold_v%0d", k), {31'b0, out_valid}, 0);
      chk($sformatf("mr_hold_rdy%0d", k), {31'b0, in_ready}, 0);
    end
    in_valid = 1'b0;
    seed_load = 1'b1;
    seed = 32'h00C0_FFEE;
    tick();
    seed_load = 1'b0;
    mlfsr = 32'h00C0_FFEE;
    beat(8'h21, 8'h43, 8'h65, 8'h87,
         sx_of(8'h21, 8'h43, 8'h65, 8'h87), "mr2");
    idle();
    pop_chk("mr2");
    idle();
    chk("mr_drain", {31'b0, out_valid}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
